// File: rtl/mac_feeder_if.sv
// Signal bundle between mac_feeder and its environment: operand stream, start command,
// MAC drive/feedback and the result handshake.
interface mac_feeder_if #(
  parameter int LEN_W = 8
);
  // Every handshake (op, cmd, res) transfers on a rising edge where valid && ready.
  // A source holds valid and its payload until that edge; ready may toggle freely.
  logic             op_valid;
  logic             op_ready;
  logic [7:0]       op_a;
  logic [7:0]       op_b;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic [7:0]       mac_a;
  logic [7:0]       mac_b;
  logic             mac_clr;
  logic [15:0]      mac_acc;
  logic             mac_of;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res;
  logic             res_of;

  modport slave (
    input  op_valid, op_a, op_b, cmd_valid, cmd_len, mac_acc, mac_of, res_ready,
    output op_ready, cmd_ready, mac_a, mac_b, mac_clr, res_valid, res, res_of
  );

  modport master (
    output op_valid, op_a, op_b, cmd_valid, cmd_len, mac_acc, mac_of, res_ready,
    input  op_ready, cmd_ready, mac_a, mac_b, mac_clr, res_valid, res, res_of
  );
endinterface

// File: rtl/mac_feeder.sv
// Sequencer for an 8x8->16 saturating MAC: buffers operand pairs, streams LEN of them
// into a freshly cleared MAC and returns the final accumulator with a sticky overflow flag.
module mac_feeder #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic        clk,
  input  logic        rn,
  mac_feeder_if.slave bus,
  output logic [2:0]  dbg_state_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    RUN    = 3'd2,
    DRAIN1 = 3'd3,
    DRAIN2 = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       mem_a [DEPTH];
  logic [7:0]       mem_b [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             full, empty, push, pop;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [7:0]       mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic             mac_clr_q, mac_clr_d;
  logic             sticky_q, sticky_d;
  logic             res_valid_q, res_valid_d;
  logic             res_of_q, res_of_d;
  logic [15:0]      res_q, res_d;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push  = bus.op_valid && !full;
  assign pop   = (state_q == RUN) && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_q[AW-1:0]] <= bus.op_a;
      mem_b[wr_q[AW-1:0]] <= bus.op_b;
    end
  end

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_clr_q   <= 1'b1;
      sticky_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_of_q    <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_clr_q   <= mac_clr_d;
      sticky_q    <= sticky_d;
      res_valid_q <= res_valid_d;
      res_of_q    <= res_of_d;
      res_q       <= res_d;
    end
  end

  // The MAC has no enable, so operands default to zero in every cycle without a pop.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    mac_a_d     = '0;
    mac_b_d     = '0;
    mac_clr_d   = 1'b0;
    sticky_d    = sticky_q;
    res_valid_d = res_valid_q;
    res_of_d    = res_of_q;
    res_d       = res_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          len_d     = bus.cmd_len;
          cnt_d     = '0;
          mac_clr_d = 1'b1;
          state_d   = CLR;
        end
      end
      CLR: begin
        sticky_d = 1'b0;
        state_d  = (len_q != '0) ? RUN : DRAIN1;
      end
      RUN: begin
        sticky_d = sticky_q | bus.mac_of;
        if (!empty) begin
          mac_a_d = mem_a[rd_q[AW-1:0]];
          mac_b_d = mem_b[rd_q[AW-1:0]];
          cnt_d   = cnt_q + 1'b1;
          if (cnt_d == len_q) state_d = DRAIN1;
        end
      end
      DRAIN1: begin
        sticky_d = sticky_q | bus.mac_of;
        state_d  = DRAIN2;
      end
      DRAIN2: begin
        // Last pair was summed one edge ago, so mac_acc is final here.
        sticky_d    = sticky_q | bus.mac_of;
        res_d       = bus.mac_acc;
        res_of_d    = sticky_q | bus.mac_of;
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.op_ready  = !full;
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;
  assign bus.mac_clr   = mac_clr_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res       = res_q;
  assign bus.res_of    = res_of_q;
  assign dbg_state_o   = state_q;
endmodule
